// File: rtl/mem_access_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : mem_access_ctrl_if
// Description : Single-port data-memory request/response bus between the
//               MEM-stage access controller (master) and data memory (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_access_ctrl_if;
  logic        o_MemReq_1;
  logic        o_MemWe_1;
  logic [31:0] o_MemAddr_32;
  logic [31:0] o_MemWData_32;
  logic        i_MemReady_1;
  logic [31:0] i_MemRData_32;

  modport master (
    output o_MemReq_1,
    output o_MemWe_1,
    output o_MemAddr_32,
    output o_MemWData_32,
    input  i_MemReady_1,
    input  i_MemRData_32
  );

  modport slave (
    input  o_MemReq_1,
    input  o_MemWe_1,
    input  o_MemAddr_32,
    input  o_MemWData_32,
    output i_MemReady_1,
    output i_MemRData_32
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mem_access_ctrl
// Description : MEM-stage data-memory sequencer. One read for loads, one write
//               for SW, read-modify-write for SH/SB. Stalls the pipeline until
//               the access completes, flags misaligned accesses and aborts on
//               a memory timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic        i_Clk_1,
  input  wire logic        i_Reset_1,
  input  wire logic        i_Valid_1,
  input  wire logic        i_Load_1,
  input  wire logic        i_Store_1,
  input  wire logic [1:0]  i_LoadStoreWidth_2,
  input  wire logic [31:0] i_Addr_32,
  input  wire logic [31:0] i_StoreData_32,
  output logic             o_Stall_1,
  output logic             o_Done_1,
  output logic [31:0]      o_LoadWord_32,
  output logic             o_Misaligned_1,
  output logic             o_BusError_1,
  mem_access_ctrl_if.master io_Mem
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Counter value on the last waiting cycle before the abort edge.
  localparam logic [7:0] c_TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_WidthByte = 2'b00;
  localparam logic [1:0] c_WidthHalf = 2'b01;

  logic [2:0]  r_State;
  logic [2:0]  w_NextState;
  logic [7:0]  r_TimeoutCnt;
  logic [1:0]  r_Width;
  logic [1:0]  r_ByteOff;
  logic [31:0] r_SData;
  logic [31:0] r_MemAddr;
  logic [31:0] r_MemWData;
  logic [31:0] r_LoadWord;
  logic        r_Misaligned;
  logic        r_BusError;

  logic        w_Accept;
  logic        w_IsWord;
  logic        w_IsHalf;
  logic        w_MisalignedIn;
  logic        w_InReq;
  logic        w_Ready;
  logic        w_Timeout;
  logic [31:0] w_Merged;

  assign w_Accept       = i_Valid_1 & (i_Load_1 | i_Store_1);
  // Width 11 is treated as a word access.
  assign w_IsWord       = i_LoadStoreWidth_2[1];
  assign w_IsHalf       = (i_LoadStoreWidth_2 == c_WidthHalf);
  assign w_MisalignedIn = (w_IsHalf & i_Addr_32[0]) | (w_IsWord & (|i_Addr_32[1:0]));
  assign w_InReq        = (r_State == S_RD) | (r_State == S_WR) |
                          (r_State == S_RMW_RD) | (r_State == S_RMW_WR);
  assign w_Ready        = io_Mem.i_MemReady_1;
  assign w_Timeout      = w_InReq & ~w_Ready & (r_TimeoutCnt == c_TimeoutLast);

  // State register.
  always_ff @(posedge i_Clk_1) begin
    if (i_Reset_1) begin
      r_State <= S_IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Next-state decode; a request state moves on only with ready or on timeout.
  always_comb begin
    w_NextState = r_State;
    case (r_State)
      S_IDLE: begin
        if (w_Accept) begin
          if (w_MisalignedIn)     w_NextState = S_DONE;
          else if (i_Load_1)      w_NextState = S_RD;
          else if (w_IsWord)      w_NextState = S_WR;
          else                    w_NextState = S_RMW_RD;
        end
      end
      S_RD, S_WR, S_RMW_WR: begin
        if (w_Ready || w_Timeout) w_NextState = S_DONE;
      end
      S_RMW_RD: begin
        if (w_Ready)              w_NextState = S_RMW_WR;
        else if (w_Timeout)       w_NextState = S_DONE;
      end
      S_DONE:  w_NextState = S_IDLE;
      default: w_NextState = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    o_Stall_1         = ((r_State == S_IDLE) & w_Accept) | w_InReq;
    o_Done_1          = (r_State == S_DONE);
    io_Mem.o_MemReq_1 = w_InReq;
    io_Mem.o_MemWe_1  = (r_State == S_WR) | (r_State == S_RMW_WR);
  end

  // Lane merge for SB/SH: replace only the addressed byte or half.
  always_comb begin
    w_Merged = io_Mem.i_MemRData_32;
    if (r_Width == c_WidthByte) begin
      case (r_ByteOff)
        2'd0:    w_Merged[7:0]   = r_SData[7:0];
        2'd1:    w_Merged[15:8]  = r_SData[7:0];
        2'd2:    w_Merged[23:16] = r_SData[7:0];
        default: w_Merged[31:24] = r_SData[7:0];
      endcase
    end else if (r_Width == c_WidthHalf) begin
      if (r_ByteOff[1]) w_Merged[31:16] = r_SData[15:0];
      else              w_Merged[15:0]  = r_SData[15:0];
    end
  end

  // Timeout counter: cleared on any state change, counts request cycles without ready.
  always_ff @(posedge i_Clk_1) begin
    if (i_Reset_1) begin
      r_TimeoutCnt <= 8'd0;
    end else if (w_NextState != r_State) begin
      r_TimeoutCnt <= 8'd0;
    end else if (w_InReq && !w_Ready) begin
      r_TimeoutCnt <= r_TimeoutCnt + 8'd1;
    end
  end

  // Access datapath: latch on accept, capture read data, build RMW write word, status pulses.
  always_ff @(posedge i_Clk_1) begin
    if (i_Reset_1) begin
      r_Width      <= 2'd0;
      r_ByteOff    <= 2'd0;
      r_SData      <= 32'd0;
      r_MemAddr    <= 32'd0;
      r_MemWData   <= 32'd0;
      r_LoadWord   <= 32'd0;
      r_Misaligned <= 1'b0;
      r_BusError   <= 1'b0;
    end else begin
      if ((r_State == S_IDLE) && w_Accept) begin
        r_Width    <= i_LoadStoreWidth_2;
        r_ByteOff  <= i_Addr_32[1:0];
        r_SData    <= i_StoreData_32;
        r_MemAddr  <= {i_Addr_32[31:2], 2'b00};
        r_MemWData <= i_StoreData_32;
      end
      if ((r_State == S_RD) && w_Ready) begin
        r_LoadWord <= io_Mem.i_MemRData_32;
      end
      if ((r_State == S_RMW_RD) && w_Ready) begin
        r_MemWData <= w_Merged;
      end
      // Both flags land exactly on the DONE cycle and clear the cycle after.
      r_Misaligned <= (r_State == S_IDLE) & w_Accept & w_MisalignedIn;
      r_BusError   <= w_Timeout;
    end
  end

  assign o_LoadWord_32        = r_LoadWord;
  assign o_Misaligned_1       = r_Misaligned;
  assign o_BusError_1         = r_BusError;
  assign io_Mem.o_MemAddr_32  = r_MemAddr;
  assign io_Mem.o_MemWData_32 = r_MemWData;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a responding
//               memory model and a scoreboard of expected memory transactions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_ctrl;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ld = 1'b0;
  logic        st = 1'b0;
  logic [1:0]  width = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] sdata = 32'd0;
  logic        stall;
  logic        done;
  logic [31:0] lword;
  logic        mis;
  logic        berr;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  txn_t        exp_q[$];
  txn_t        m_Exp;
  int          g_Delay = 0;
  bit          g_Stuck = 1'b0;
  int          g_Wcnt = 0;
  int          g_ReqCycles = 0;
  logic [31:0] g_MemWord = 32'd0;

  mem_access_ctrl_if u_if ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (
    .i_Clk_1            (clk),
    .i_Reset_1          (rst),
    .i_Valid_1          (valid),
    .i_Load_1           (ld),
    .i_Store_1          (st),
    .i_LoadStoreWidth_2 (width),
    .i_Addr_32          (addr),
    .i_StoreData_32     (sdata),
    .o_Stall_1          (stall),
    .o_Done_1           (done),
    .o_LoadWord_32      (lword),
    .o_Misaligned_1     (mis),
    .o_BusError_1       (berr),
    .io_Mem             (u_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: decides ready away from the edge; each granted request is scoreboarded.
  initial begin
    u_if.i_MemReady_1  = 1'b0;
    u_if.i_MemRData_32 = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      u_if.i_MemRData_32 = g_MemWord;
      if (rst || !u_if.o_MemReq_1) begin
        u_if.i_MemReady_1 = 1'b0;
        g_Wcnt = 0;
      end else begin
        g_ReqCycles++;
        if (!g_Stuck && g_Wcnt >= g_Delay) begin
          u_if.i_MemReady_1 = 1'b1;
          g_Wcnt = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_txn: got we=%0b addr=%h wdata=%h, required no transaction",
                     u_if.o_MemWe_1, u_if.o_MemAddr_32, u_if.o_MemWData_32);
          end else begin
            m_Exp = exp_q.pop_front();
            if (u_if.o_MemWe_1 !== m_Exp.we || u_if.o_MemAddr_32 !== m_Exp.addr ||
                (m_Exp.we && u_if.o_MemWData_32 !== m_Exp.wdata)) begin
              n_fail++;
              $display("FAIL mem_txn: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                       u_if.o_MemWe_1, u_if.o_MemAddr_32, u_if.o_MemWData_32,
                       m_Exp.we, m_Exp.addr, m_Exp.wdata);
            end
          end
        end else begin
          u_if.i_MemReady_1 = 1'b0;
          g_Wcnt++;
        end
      end
    end
  end

  // Drive one instruction and wait (bounded) for Done; inputs held stable meanwhile.
  task automatic run_op(input bit l, input bit s, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output bit stall_ok, output bit stall_at_done,
                        output bit mis_o, output bit berr_o);
    int t0;
    @(negedge clk);
    valid = 1'b1; ld = l; st = s; width = w; addr = a; sdata = d;
    t0 = cyc;
    #2;
    stall_ok = (stall === 1'b1);
    lat = -1; stall_at_done = 1'b1; mis_o = 1'b0; berr_o = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #2;
      if (done === 1'b1) begin
        lat = cyc - t0;
        stall_at_done = stall;
        mis_o = mis;
        berr_o = berr;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    valid = 1'b0; ld = 1'b0; st = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if ({stall, done, mis, berr, u_if.o_MemReq_1, u_if.o_MemWe_1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {stall, done, mis, berr, u_if.o_MemReq_1, u_if.o_MemWe_1});
    end
    n_checks++;
    if (lword !== 32'd0 || u_if.o_MemAddr_32 !== 32'd0 || u_if.o_MemWData_32 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got lword=%h addr=%h wdata=%h, required all 0",
               lword, u_if.o_MemAddr_32, u_if.o_MemWData_32);
    end
    rst = 1'b0;
  endtask

  task automatic test_nonmem();
    bit bad = 1'b0;
    @(negedge clk);
    valid = 1'b1; ld = 1'b0; st = 1'b0; width = 2'b10; addr = 32'h104;
    for (int k = 0; k < 3; k++) begin
      #2;
      if (stall !== 1'b0 || done !== 1'b0 || u_if.o_MemReq_1 !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL nonmem: got stall/done/req activity, required none");
    end
  endtask

  task automatic test_load();
    int lat; bit sok, sdone, m, b;
    g_MemWord = 32'hDEADBEEF;
    exp_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    run_op(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, lat, sok, sdone, m, b);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d, required 2", lat); end
    n_checks++;
    if (!sok || sdone !== 1'b0) begin
      n_fail++; $display("FAIL lw_stall: got ok=%0b at_done=%0b, required ok=1 at_done=0", sok, sdone);
    end
    n_checks++;
    if (lword !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h, required deadbeef", lword); end
    // Load and store both set: load wins.
    g_MemWord = 32'h0BADF00D;
    exp_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
    run_op(1'b1, 1'b1, 2'b11, 32'h104, 32'h55555555, lat, sok, sdone, m, b);
    n_checks++;
    if (lat !== 2 || lword !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL load_wins: got lat=%0d lword=%h, required lat=2 lword=0badf00d", lat, lword);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL lw_txn_count: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_store();
    int lat; bit sok, sdone, m, b;
    g_MemWord = 32'h11223344;
    exp_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    exp_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hAB223344});
    run_op(1'b0, 1'b1, 2'b00, 32'h203, 32'hFFFFFFAB, lat, sok, sdone, m, b);
    n_checks++;
    if (lat !== 3 || !sok) begin n_fail++; $display("FAIL sb_latency: got %0d stall_ok=%0b, required 3/1", lat, sok); end
    exp_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    exp_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'h112233AB});
    run_op(1'b0, 1'b1, 2'b00, 32'h200, 32'h000000AB, lat, sok, sdone, m, b);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL sb_lane0_latency: got %0d, required 3", lat); end
    exp_q.push_back('{we: 1'b0, addr: 32'h208, wdata: 32'h0});
    exp_q.push_back('{we: 1'b1, addr: 32'h208, wdata: 32'h1122BEEF});
    run_op(1'b0, 1'b1, 2'b01, 32'h208, 32'h9999BEEF, lat, sok, sdone, m, b);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL sh_lo_latency: got %0d, required 3", lat); end
    exp_q.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'hA5A55A5A});
    run_op(1'b0, 1'b1, 2'b10, 32'h300, 32'hA5A55A5A, lat, sok, sdone, m, b);
    n_checks++;
    if (lat !== 2 || !sok) begin n_fail++; $display("FAIL sw_latency: got %0d stall_ok=%0b, required 2/1", lat, sok); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL store_txn_count: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_sh_wait();
    int lat; bit sok, sdone, m, b;
    g_MemWord = 32'h11223344;
    g_Delay = 3;
    exp_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    exp_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hCAFE3344});
    run_op(1'b0, 1'b1, 2'b01, 32'h202, 32'h1234CAFE, lat, sok, sdone, m, b);
    g_Delay = 0;
    n_checks++;
    if (lat !== 9 || !sok) begin n_fail++; $display("FAIL sh_wait_latency: got %0d stall_ok=%0b, required 9/1", lat, sok); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sh_wait_txn_count: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_misaligned();
    int lat; bit sok, sdone, m, b;
    g_ReqCycles = 0;
    run_op(1'b1, 1'b0, 2'b01, 32'h101, 32'h0, lat, sok, sdone, m, b);
    n_checks++;
    if (lat !== 1 || m !== 1'b1 || b !== 1'b0) begin
      n_fail++; $display("FAIL lh_misaligned: got lat=%0d mis=%0b berr=%0b, required 1/1/0", lat, m, b);
    end
    run_op(1'b0, 1'b1, 2'b10, 32'h102, 32'h12345678, lat, sok, sdone, m, b);
    n_checks++;
    if (lat !== 1 || m !== 1'b1 || !sok) begin
      n_fail++; $display("FAIL sw_misaligned: got lat=%0d mis=%0b stall_ok=%0b, required 1/1/1", lat, m, sok);
    end
    @(negedge clk); #2;
    n_checks++;
    if (g_ReqCycles !== 0 || mis !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_noreq: got req_cycles=%0d mis=%0b, required 0/0", g_ReqCycles, mis);
    end
  endtask

  task automatic test_timeout();
    int lat; bit sok, sdone, m, b;
    g_Stuck = 1'b1;
    g_ReqCycles = 0;
    run_op(1'b0, 1'b1, 2'b10, 32'h400, 32'h77777777, lat, sok, sdone, m, b);
    g_Stuck = 1'b0;
    n_checks++;
    if (lat !== 5 || b !== 1'b1 || m !== 1'b0) begin
      n_fail++; $display("FAIL timeout: got lat=%0d berr=%0b mis=%0b, required 5/1/0", lat, b, m);
    end
    n_checks++;
    if (g_ReqCycles !== 4 || u_if.o_MemReq_1 !== 1'b0) begin
      n_fail++; $display("FAIL timeout_req: got req_cycles=%0d req=%0b, required 4/0", g_ReqCycles, u_if.o_MemReq_1);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit sok, sdone, m, b;
    bit saw_done = 1'b0;
    g_Stuck = 1'b1;
    g_MemWord = 32'h11223344;
    @(negedge clk);
    valid = 1'b1; ld = 1'b0; st = 1'b1; width = 2'b00; addr = 32'h503; sdata = 32'h000000EE;
    repeat (3) begin
      @(negedge clk); #2;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1; valid = 1'b0; st = 1'b0;
    @(negedge clk); #2;
    if (done === 1'b1) saw_done = 1'b1;
    n_checks++;
    if ({stall, done, mis, berr, u_if.o_MemReq_1} !== 5'b0 || lword !== 32'd0 ||
        u_if.o_MemAddr_32 !== 32'd0 || u_if.o_MemWData_32 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got ctrl=%b lword=%h addr=%h wdata=%h, required all 0",
               {stall, done, mis, berr, u_if.o_MemReq_1}, lword, u_if.o_MemAddr_32, u_if.o_MemWData_32);
    end
    rst = 1'b0;
    g_Stuck = 1'b0;
    @(negedge clk); #2;
    if (done === 1'b1) saw_done = 1'b1;
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL reset_mid_done: got done pulse, required none"); end
    g_MemWord = 32'hFEEDFACE;
    exp_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0});
    run_op(1'b1, 1'b0, 2'b10, 32'h600, 32'h0, lat, sok, sdone, m, b);
    n_checks++;
    if (lat !== 2 || lword !== 32'hFEEDFACE || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL reset_mid_recover: got lat=%0d lword=%h pending=%0d, required 2/feedface/0",
                         lat, lword, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_sh_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
